// File: rtl/rtype_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rtype_sequencer_pkg
// Shared definitions for the R-type instruction sequencer and the blocks that
// sit next to it (register-file/ALU stage, top-level wrappers).
//   state_t            : sequencer FSM states
//   OP_RTYPE           : primary opcode of every R-type instruction
//   ALUOP_RTYPE/ADD    : ALU-control selector values
//   HALT_WORD_DEFAULT  : instruction encoding that stops execution
//   sat_inc16()        : 16-bit saturating increment used by the counters
// ---------------------------------------------------------------------------
package rtype_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [5:0]  OP_RTYPE          = 6'b000000;
    localparam logic [1:0]  ALUOP_RTYPE       = 2'b10;
    localparam logic [1:0]  ALUOP_ADD         = 2'b00;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Counters stick at all-ones instead of wrapping to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/rtype_sequencer.sv
// ---------------------------------------------------------------------------
// rtype_sequencer
// Multi-cycle sequencer that walks an instruction memory from address 0,
// decodes R-type instructions and steers an external register-file/ALU stage.
// Each instruction takes FETCH -> DECODE -> EXEC -> WB (4 cycles). Execution
// stops on HALT_WORD or after the last memory word; PC never wraps.
//
// Ports
//   clock, reset            : single clock, synchronous active-high reset
//   start                   : one-cycle request to run from PC 0 (IDLE/HALT)
//   imem_addr / imem_data   : instruction memory (combinational read)
//   Read1, Read2, WriteReg  : register-file addresses (rs, rt, rd)
//   WriteData, RegWrite     : write-back value and one-cycle write enable
//   FuncCode, ALUOp         : funct field and ALU-control selector
//   ALUOut, Zero            : result and zero flag from the ALU stage
//   busy, done, illegal     : status (illegal is sticky until next start)
//   instr_count, zero_count : saturating statistics counters
// ---------------------------------------------------------------------------
module rtype_sequencer
    import rtype_sequencer_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT,
    localparam int         PC_W       = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    output logic [5:0]      Read1,
    output logic [5:0]      Read2,
    output logic [5:0]      WriteReg,
    output logic [31:0]     WriteData,
    output logic            RegWrite,
    output logic [5:0]      FuncCode,
    output logic [1:0]      ALUOp,
    input  logic [31:0]     ALUOut,
    input  logic            Zero,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [15:0]     instr_count,
    output logic [15:0]     zero_count
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(IMEM_DEPTH - 1);

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [31:0]     ir_reg, ir_next;
    logic [31:0]     result_reg, result_next;
    logic [15:0]     instr_count_reg, instr_count_next;
    logic [15:0]     zero_count_reg, zero_count_next;
    logic            illegal_reg, illegal_next;

    // Instruction fields, held in IR from DECODE through WB.
    logic [5:0] ir_opcode;
    logic [4:0] ir_rs, ir_rt, ir_rd;
    logic [5:0] ir_funct;
    logic       ir_is_rtype;

    assign ir_opcode   = ir_reg[31:26];
    assign ir_rs       = ir_reg[25:21];
    assign ir_rt       = ir_reg[20:16];
    assign ir_rd       = ir_reg[15:11];
    assign ir_funct    = ir_reg[5:0];
    // The halt word never reaches EXEC/WB, so an opcode check is enough here.
    assign ir_is_rtype = (ir_opcode == OP_RTYPE);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= '0;
            ir_reg          <= '0;
            result_reg      <= '0;
            instr_count_reg <= '0;
            zero_count_reg  <= '0;
            illegal_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            ir_reg          <= ir_next;
            result_reg      <= result_next;
            instr_count_reg <= instr_count_next;
            zero_count_reg  <= zero_count_next;
            illegal_reg     <= illegal_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        ir_next          = ir_reg;
        result_next      = result_reg;
        instr_count_next = instr_count_reg;
        zero_count_next  = zero_count_reg;
        illegal_next     = illegal_reg;

        unique case (state_reg)
            // Start is only honoured while stopped; a run always begins at PC 0
            // with fresh statistics.
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_next       = ST_FETCH;
                    pc_next          = '0;
                    instr_count_next = '0;
                    zero_count_next  = '0;
                    illegal_next     = 1'b0;
                end
            end

            ST_FETCH: begin
                ir_next    = imem_data;
                state_next = ST_DECODE;
            end

            ST_DECODE: begin
                if (ir_reg == HALT_WORD) begin
                    state_next = ST_HALT;
                end else if (ir_is_rtype) begin
                    state_next = ST_EXEC;
                end else begin
                    // Unsupported opcode: flag it and retire without a write.
                    illegal_next = 1'b1;
                    state_next   = ST_WB;
                end
            end

            ST_EXEC: begin
                result_next = ALUOut;
                if (Zero) begin
                    zero_count_next = sat_inc16(zero_count_reg);
                end
                state_next = ST_WB;
            end

            ST_WB: begin
                instr_count_next = sat_inc16(instr_count_reg);
                if (pc_reg == PC_LAST) begin
                    state_next = ST_HALT;
                end else begin
                    pc_next    = pc_reg + PC_W'(1);
                    state_next = ST_FETCH;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign imem_addr = pc_reg;
    assign Read1     = {1'b0, ir_rs};
    assign Read2     = {1'b0, ir_rt};
    assign WriteReg  = {1'b0, ir_rd};
    assign FuncCode  = ir_funct;
    assign WriteData = result_reg;

    // Writes to register 0 are suppressed; illegal instructions never write.
    assign RegWrite = (state_reg == ST_WB) && ir_is_rtype && (ir_rd != 5'd0);

    always_comb begin
        ALUOp = ALUOP_ADD;
        if (ir_is_rtype &&
            ((state_reg == ST_DECODE) || (state_reg == ST_EXEC) || (state_reg == ST_WB))) begin
            ALUOp = ALUOP_RTYPE;
        end
    end

    assign busy        = (state_reg == ST_FETCH) || (state_reg == ST_DECODE) ||
                         (state_reg == ST_EXEC)  || (state_reg == ST_WB);
    assign done        = (state_reg == ST_HALT);
    assign illegal     = illegal_reg;
    assign instr_count = instr_count_reg;
    assign zero_count  = zero_count_reg;

endmodule

// File: tb/tb_rtype_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rtype_sequencer
// Self-checking bench: a program-level reference model predicts the list of
// register writes and the final counters for each program; a monitor pops the
// expected writes whenever RegWrite pulses.
// ---------------------------------------------------------------------------
module tb_rtype_sequencer;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int          DEPTH = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic [5:0]  Read1, Read2, WriteReg, FuncCode;
    logic [31:0] WriteData, ALUOut;
    logic        RegWrite, Zero, busy, done, illegal;
    logic [1:0]  ALUOp;
    logic [15:0] instr_count, zero_count;

    logic [31:0] imem [0:DEPTH-1];

    // Stand-in ALU stage: deterministic function of the operands, or a forced value.
    logic        alu_force = 1'b0;
    logic [31:0] force_val = '0;
    logic        force_zero = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [37:0] exp_q[$];
    logic [37:0] exp_w;

    rtype_sequencer dut (
        .clock(clock), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg),
        .WriteData(WriteData), .RegWrite(RegWrite),
        .FuncCode(FuncCode), .ALUOp(ALUOp),
        .ALUOut(ALUOut), .Zero(Zero),
        .busy(busy), .done(done), .illegal(illegal),
        .instr_count(instr_count), .zero_count(zero_count)
    );

    always #5 clock = ~clock;

    assign imem_data = imem[imem_addr];

    function automatic logic [31:0] alu_raw(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [5:0] fn);
        // Odd funct codes yield zero so the zero counter gets exercised.
        return fn[0] ? 32'd0 : ({16'd0, rs, rt, fn} + 32'h100);
    endfunction

    logic [31:0] raw_now;
    always_comb begin
        raw_now = alu_raw(Read1[4:0], Read2[4:0], FuncCode);
        ALUOut  = alu_force ? force_val : raw_now;
        Zero    = alu_force ? force_zero : (raw_now == 32'd0);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Program-level model: run the memory image from word 0 and predict writes/counters.
    int  m_cnt, m_zc;
    bit  m_ill;
    task automatic run_model();
        logic [31:0] w, v;
        bit z;
        m_cnt = 0; m_zc = 0; m_ill = 0;
        for (int pc = 0; pc < DEPTH; pc++) begin
            w = imem[pc];
            if (w == HALT) break;
            m_cnt++;
            if (w[31:26] == 6'd0) begin
                v = alu_force ? force_val : alu_raw(w[25:21], w[20:16], w[5:0]);
                z = alu_force ? force_zero : (v == 32'd0);
                if (z) m_zc++;
                if (w[15:11] != 5'd0) exp_q.push_back({1'b0, w[15:11], v});
            end else begin
                m_ill = 1;
            end
        end
    endtask

    // Monitor: every RegWrite pulse must match the next predicted write.
    always @(negedge clock) begin
        if (RegWrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, required no write",
                         WriteReg, WriteData);
            end else begin
                exp_w = exp_q.pop_front();
                if ({WriteReg, WriteData} !== exp_w) begin
                    errors++;
                    $display("FAIL write: got rd=%0d data=%h, required rd=%0d data=%h",
                             WriteReg, WriteData, exp_w[37:32], exp_w[31:0]);
                end else begin
                    $display("WB rd=%0d data=%h", WriteReg, WriteData);
                end
            end
        end
    end

    // Returns at the negedge where the DUT sits in FETCH of word 0.
    task automatic do_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    task automatic begin_run();
        run_model();
        do_start();
    endtask

    task automatic finish_run(input string tag, input bit poke_start);
        int n;
        n = 0;
        while (!done && n < DEPTH * 4 + 20) begin
            @(negedge clock);
            n++;
            // Start while busy must be ignored.
            if (poke_start && n == 5 && busy) begin
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
                n++;
            end
        end
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " instr_count"}, {16'd0, instr_count}, m_cnt);
        check({tag, " zero_count"}, {16'd0, zero_count}, m_zc);
        check({tag, " illegal"}, {31'd0, illegal}, {31'd0, m_ill});
        check({tag, " pending_writes"}, exp_q.size(), 32'd0);
        $display("RUN %s instr=%0d zero=%0d illegal=%0d", tag, instr_count, zero_count, illegal);
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < DEPTH; i++) imem[i] = w;
    endtask

    function automatic logic [31:0] rand_rtype();
        return {6'd0, 26'($urandom)};
    endfunction

    initial begin
        fill(HALT);

        // Reset values
        repeat (3) @(negedge clock);
        check("rst busy", {31'd0, busy}, 0);
        check("rst done", {31'd0, done}, 0);
        check("rst regwrite", {31'd0, RegWrite}, 0);
        check("rst illegal", {31'd0, illegal}, 0);
        check("rst aluop", {30'd0, ALUOp}, 0);
        check("rst counts", {instr_count, zero_count}, 0);
        check("rst pc/data", {imem_addr, 26'd0} | WriteData, 0);
        reset = 1'b0;

        // add r3 = r1 + r2 with ALUOut forced to 12; cycle-exact checks
        imem[0] = 32'h00221820; imem[1] = HALT;
        alu_force = 1; force_val = 32'd12; force_zero = 0;
        begin_run();
        check("add fetch addr", {26'd0, imem_addr}, 0);
        check("add fetch busy", {31'd0, busy}, 1);
        @(negedge clock);
        check("add decode Read1", {26'd0, Read1}, 1);
        check("add decode Read2", {26'd0, Read2}, 2);
        check("add decode FuncCode", {26'd0, FuncCode}, 32'h20);
        check("add decode ALUOp", {30'd0, ALUOp}, 2);
        check("add decode no write", {31'd0, RegWrite}, 0);
        @(negedge clock);
        check("add exec no write", {31'd0, RegWrite}, 0);
        @(negedge clock);
        check("add wb RegWrite", {31'd0, RegWrite}, 1);
        check("add wb WriteReg", {26'd0, WriteReg}, 3);
        check("add wb WriteData", WriteData, 12);
        finish_run("add", 0);

        // sub into rd0 with Zero: no write, zero_count counts
        imem[0] = 32'h00220022; imem[1] = HALT;
        force_val = 32'd0; force_zero = 1;
        begin_run();
        finish_run("sub_rd0", 0);
        alu_force = 0;

        // illegal opcode, then R-type, then halt at address 2
        imem[0] = 32'h8C220004; imem[1] = 32'h00221820; imem[2] = HALT;
        begin_run();
        @(negedge clock);
        @(negedge clock);
        check("lw wb no write", {31'd0, RegWrite}, 0);
        check("lw illegal set", {31'd0, illegal}, 1);
        @(negedge clock);
        check("lw next pc", {26'd0, imem_addr}, 1);
        finish_run("illegal_halt2", 0);

        // Restart from HALT clears everything
        begin_run();
        check("restart pc", {26'd0, imem_addr}, 0);
        check("restart counts", {instr_count, zero_count}, 0);
        check("restart illegal", {31'd0, illegal}, 0);
        finish_run("restart", 0);

        // Full memory of R-type, no halt word: stops after the last address
        for (int i = 0; i < DEPTH; i++) imem[i] = rand_rtype();
        begin_run();
        finish_run("full", 0);
        check("full instr_count", {16'd0, instr_count}, 64);
        check("full last pc", {26'd0, imem_addr}, 63);

        // Reset during EXEC: back to IDLE, write dropped
        fill(HALT);
        imem[0] = 32'h00221820;
        do_start();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst busy", {31'd0, busy}, 0);
        check("midrst done", {31'd0, done}, 0);
        check("midrst aluop", {30'd0, ALUOp}, 0);
        check("midrst instr_count", {16'd0, instr_count}, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("midrst no write", {31'd0, RegWrite}, 0);
            @(negedge clock);
        end
        check("midrst idle", {31'd0, busy | done}, 0);

        // Randomized programs with illegal ops, random halt position, stray starts
        for (int t = 0; t < 6; t++) begin
            int hpos;
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 7) == 0)
                    imem[i] = {6'($urandom_range(1, 62)), 26'($urandom)};
                else
                    imem[i] = rand_rtype();
            end
            hpos = $urandom_range(0, DEPTH + 10);
            if (hpos < DEPTH) imem[hpos] = HALT;
            begin_run();
            finish_run($sformatf("rand%0d", t), 1);
        end

        repeat (4) @(negedge clock);
        check("final pending_writes", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
